tetris_ctrl: RTL and testbench
==============================

// Module: tetris_ctrl
// PURPOSE
// Game-sequencing master for the tetris engine: issues command strobes (gen_random, isdie, moveT, move_down,
// remove_1, shift, remove_2, stop, auto_down) and consumes its completions (move_comp, down_comp, die,
// shift_finish, remove_2_finish). Sits between debounced one-shot keys and the engine; owns gravity timing,
// pause, and the spawn -> play -> lock -> clear -> spawn loop.
// PARAMETERS
// DROP_TICKS   25_000_000  gravity period in clk cycles (>=2)
// DIE_LAT      2           cycles after isdie before die is sampled (>=1)
// ACK_TIMEOUT  1024        max cycles a held request waits for its completion
// PORTS
// clk              in   1   system clock
// clr              in   1   reset, asynchronous, active-high
// U,D,L,R          in   1   one-cycle key pulses (rotate/soft-drop/left/right)
// pause            in   1   one-cycle pause toggle pulse
// move_comp        in   1   engine: move/rotate/step-down done, piece still live
// down_comp        in   1   engine: step-down impossible, piece locked
// die              in   1   engine: spawn collides (valid DIE_LAT cycles after isdie)
// shift_finish     in   1   engine: row collapse done
// remove_2_finish  in   1   engine: clear commit done
// gen_random       out  1   spawn new piece (1-cycle pulse)
// isdie            out  1   death check (1-cycle pulse)
// moveT            out  1   move/rotate request, held until move_comp
// u,l,r,d          out  1   one-hot direction, valid while moveT=1, else 0
// move_down        out  1   step-down request, held until move_comp or down_comp
// auto_down        out  1   1 = current move_down is gravity-caused, 0 = key D
// remove_1         out  1   mark full rows (1-cycle pulse)
// shift            out  1   collapse request, held until shift_finish
// remove_2         out  1   commit request, held until remove_2_finish
// stop             out  1   engine freeze; 1 in PAUSE and OVER
// err              out  1   sticky: a request timed out; cleared only by clr
// piece_cnt        out  16  pieces spawned since reset, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset: all outputs 0, piece_cnt=0, key/pause/gravity latches cleared, state=SPAWN. clr mid-handshake
//   drops any held request immediately (asynchronous).
// - All outputs registered (Moore); requests deassert the cycle after the completion is sampled high.
// - SPAWN: gen_random=1 one cycle, piece_cnt+=1 -> CHECK.
// - CHECK: isdie=1 first cycle; wait DIE_LAT cycles, sample die: 1 -> OVER, 0 -> PLAY.
// - PLAY: pending pause -> PAUSE; else pending gravity -> DROP(auto_down=1); else pending key, priority
//   D>L>R>U: D -> DROP(auto_down=0), L/R/U -> MOVE with l/r/u. Otherwise stay.
// - MOVE: moveT + dir held until move_comp -> PLAY.
// - DROP: move_down held; move_comp -> PLAY; down_comp -> MARK; both same cycle: down_comp wins.
// - MARK: remove_1 one cycle -> SHIFT (shift until shift_finish) -> COMMIT (remove_2 until
//   remove_2_finish) -> SPAWN.
// - PAUSE: stop=1, gravity counter frozen; pause pulse -> PLAY. Keys arriving in PAUSE discarded.
// - OVER: stop=1, terminal until clr; all inputs ignored.
// - Gravity: counter runs in every state except PAUSE/OVER; at DROP_TICKS-1 wraps to 0 and sets
//   pending_drop (one-deep, extra expiries merge). Cleared when DROP entered with auto_down=1, and on SPAWN.
// - Keys: one-deep latch per direction, set on pulse outside PAUSE/OVER, cleared when served and on SPAWN
//   (keys during lock/clear are dropped). Same-cycle key pulse and service: latch stays set.
// - Pause pulse outside PLAY/PAUSE latched, taken at next PLAY; in OVER ignored.
// - Timeout: in MOVE/DROP/SHIFT/COMMIT a counter reset on entry; at ACK_TIMEOUT cycles without completion
//   request drops, err=1; MOVE/DROP -> PLAY, SHIFT/COMMIT -> SPAWN.
// STRUCTURE
// - tetris_pkg.vh: state localparams (SPAWN,CHECK,PLAY,MOVE,DROP,MARK,SHIFT,COMMIT,PAUSE,OVER; 4-bit),
//   direction one-hot constants shared with the engine.
// - Sub-module tetris_gravity_timer (DROP_TICKS, enable, tick pulse); rest is one FSM + latches.
// TESTING
// - Reset release, engine idle-responds die=0 -> gen_random pulse at cycle 1, isdie at 2, PLAY; piece_cnt=1.
// - Pulse L in PLAY, move_comp 3 cycles later -> moveT=1,l=1 for exactly 3 cycles then 0; back in PLAY.
// - DROP_TICKS=8, no keys -> move_down auto_down=1 every 8 cycles; answer down_comp -> remove_1 pulse,
//   shift until shift_finish, remove_2 until remove_2_finish, then gen_random; piece_cnt=2.
// - D and R pulsed same cycle with gravity pending -> DROP(auto_down=1) first, then DROP(auto_down=0), then MOVE r.
// - die=1 at CHECK -> OVER, stop=1, further keys produce no requests until clr.
// - ACK_TIMEOUT=16, withhold shift_finish -> shift drops after 16 cycles, err=1, gen_random next; clr clears err.

Source files
------------

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared state encoding and direction constants for the tetris sequencer
package tetris_pkg;

    typedef enum logic [3:0] {
        ST_SPAWN  = 4'd0,
        ST_CHECK  = 4'd1,
        ST_PLAY   = 4'd2,
        ST_MOVE   = 4'd3,
        ST_DROP   = 4'd4,
        ST_MARK   = 4'd5,
        ST_SHIFT  = 4'd6,
        ST_COMMIT = 4'd7,
        ST_PAUSE  = 4'd8,
        ST_OVER   = 4'd9
    } state_t;

    // One-hot move directions as seen by the engine: {d, r, l, u}
    localparam logic [3:0] DIR_NONE = 4'b0000;
    localparam logic [3:0] DIR_U    = 4'b0001;
    localparam logic [3:0] DIR_L    = 4'b0010;
    localparam logic [3:0] DIR_R    = 4'b0100;
    localparam logic [3:0] DIR_D    = 4'b1000;

    // Width of the shared wait/timeout counter
    localparam int TCNT_W = 16;

endpackage

// File: rtl/tetris_gravity_timer.sv
// rtl/tetris_gravity_timer.sv - free-running gravity period counter with freeze enable
module tetris_gravity_timer #(
    parameter int DROP_TICKS = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int W = (DROP_TICKS > 2) ? $clog2(DROP_TICKS) : 1;

    logic [W-1:0] cnt;
    logic         at_end;

    assign at_end = (cnt == W'(DROP_TICKS - 1));
    // tick marks the cycle in which the counter wraps; the FSM latches it
    assign tick   = enable && at_end;

    // Count while enabled, wrapping at the end of the period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tetris_ctrl.sv
// rtl/tetris_ctrl.sv - game-sequencing master: spawn, play, lock, clear loop with gravity and pause
module tetris_ctrl
    import tetris_pkg::*;
#(
    parameter int DROP_TICKS  = 25_000_000,
    parameter int DIE_LAT     = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        U,
    input  logic        D,
    input  logic        L,
    input  logic        R,
    input  logic        pause,
    input  logic        move_comp,
    input  logic        down_comp,
    input  logic        die,
    input  logic        shift_finish,
    input  logic        remove_2_finish,
    output logic        gen_random,
    output logic        isdie,
    output logic        moveT,
    output logic        u,
    output logic        l,
    output logic        r,
    output logic        d,
    output logic        move_down,
    output logic        auto_down,
    output logic        remove_1,
    output logic        shift,
    output logic        remove_2,
    output logic        stop,
    output logic        err,
    output logic [15:0] piece_cnt
);

    state_t              state;
    logic [TCNT_W-1:0]   tcnt;
    logic [3:0]          dir;
    logic                key_u, key_l, key_r, key_d;
    logic                pend_pause, pend_drop;
    logic                tick;
    logic                grav_en, key_ok, timeout, die_due;
    logic                take_pause, take_drop, serve_d, serve_l, serve_r, serve_u;

    assign u = dir[0];
    assign l = dir[1];
    assign r = dir[2];
    assign d = dir[3];

    assign grav_en = (state != ST_PAUSE) && (state != ST_OVER);
    assign key_ok  = grav_en;
    assign timeout = (tcnt == TCNT_W'(ACK_TIMEOUT - 1));
    assign die_due = (tcnt == TCNT_W'(DIE_LAT + 1));

    tetris_gravity_timer #(.DROP_TICKS(DROP_TICKS)) u_gravity (
        .clk    (clk),
        .rst    (clr),
        .enable (grav_en),
        .tick   (tick)
    );

    // Decide which pending event PLAY serves this cycle (pause > gravity > D > L > R > U)
    always_comb begin
        take_pause = 1'b0;
        take_drop  = 1'b0;
        serve_d    = 1'b0;
        serve_l    = 1'b0;
        serve_r    = 1'b0;
        serve_u    = 1'b0;
        if (state == ST_PLAY) begin
            if (pend_pause)     take_pause = 1'b1;
            else if (pend_drop) take_drop  = 1'b1;
            else if (key_d)     serve_d    = 1'b1;
            else if (key_l)     serve_l    = 1'b1;
            else if (key_r)     serve_r    = 1'b1;
            else if (key_u)     serve_u    = 1'b1;
        end
    end

    // One-deep latches for keys, pause and gravity; a fresh pulse outlives a same-cycle service
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            key_u      <= 1'b0;
            key_l      <= 1'b0;
            key_r      <= 1'b0;
            key_d      <= 1'b0;
            pend_pause <= 1'b0;
            pend_drop  <= 1'b0;
        end else begin
            if (state == ST_SPAWN) begin
                key_u <= 1'b0;
                key_l <= 1'b0;
                key_r <= 1'b0;
                key_d <= 1'b0;
            end else begin
                if (U && key_ok)  key_u <= 1'b1;
                else if (serve_u) key_u <= 1'b0;
                if (L && key_ok)  key_l <= 1'b1;
                else if (serve_l) key_l <= 1'b0;
                if (R && key_ok)  key_r <= 1'b1;
                else if (serve_r) key_r <= 1'b0;
                if (D && key_ok)  key_d <= 1'b1;
                else if (serve_d) key_d <= 1'b0;
            end

            // In PAUSE the pulse resumes play directly and is not latched
            if (pause && key_ok)    pend_pause <= 1'b1;
            else if (take_pause)    pend_pause <= 1'b0;

            if (state == ST_SPAWN)  pend_drop <= 1'b0;
            else if (tick)          pend_drop <= 1'b1;
            else if (take_drop)     pend_drop <= 1'b0;
        end
    end

    // Main sequencing FSM with registered (Moore) command outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= ST_SPAWN;
            tcnt       <= '0;
            dir        <= DIR_NONE;
            gen_random <= 1'b0;
            isdie      <= 1'b0;
            moveT      <= 1'b0;
            move_down  <= 1'b0;
            auto_down  <= 1'b0;
            remove_1   <= 1'b0;
            shift      <= 1'b0;
            remove_2   <= 1'b0;
            stop       <= 1'b0;
            err        <= 1'b0;
            piece_cnt  <= 16'd0;
        end else begin
            gen_random <= 1'b0;
            isdie      <= 1'b0;
            remove_1   <= 1'b0;
            case (state)
                ST_SPAWN: begin
                    gen_random <= 1'b1;
                    piece_cnt  <= piece_cnt + 16'd1;
                    tcnt       <= '0;
                    state      <= ST_CHECK;
                end
                ST_CHECK: begin
                    isdie <= (tcnt == '0);
                    if (die_due) begin
                        tcnt  <= '0;
                        stop  <= die;
                        state <= die ? ST_OVER : ST_PLAY;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_PLAY: begin
                    tcnt <= '0;
                    if (take_pause) begin
                        stop  <= 1'b1;
                        state <= ST_PAUSE;
                    end else if (take_drop || serve_d) begin
                        move_down <= 1'b1;
                        auto_down <= take_drop;
                        state     <= ST_DROP;
                    end else if (serve_l || serve_r || serve_u) begin
                        moveT <= 1'b1;
                        dir   <= serve_l ? DIR_L : (serve_r ? DIR_R : DIR_U);
                        state <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (move_comp || timeout) begin
                        moveT <= 1'b0;
                        dir   <= DIR_NONE;
                        err   <= err | ~move_comp;
                        state <= ST_PLAY;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_DROP: begin
                    // A lock report outranks a same-cycle move_comp
                    if (down_comp) begin
                        move_down <= 1'b0;
                        auto_down <= 1'b0;
                        remove_1  <= 1'b1;
                        state     <= ST_MARK;
                    end else if (move_comp || timeout) begin
                        move_down <= 1'b0;
                        auto_down <= 1'b0;
                        err       <= err | ~move_comp;
                        state     <= ST_PLAY;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_MARK: begin
                    shift <= 1'b1;
                    tcnt  <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (shift_finish) begin
                        shift    <= 1'b0;
                        remove_2 <= 1'b1;
                        tcnt     <= '0;
                        state    <= ST_COMMIT;
                    end else if (timeout) begin
                        shift <= 1'b0;
                        err   <= 1'b1;
                        state <= ST_SPAWN;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (remove_2_finish || timeout) begin
                        remove_2 <= 1'b0;
                        err      <= err | ~remove_2_finish;
                        state    <= ST_SPAWN;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (pause) begin
                        stop  <= 1'b0;
                        state <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    stop <= 1'b1;
                end
                default: begin
                    state <= ST_SPAWN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_ctrl.sv
// tb/tb_tetris_ctrl.sv - directed self-checking bench for tetris_ctrl
module tb_tetris_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        U = 0, D = 0, L = 0, R = 0, pause = 0;
    logic        move_comp = 0, down_comp = 0, die = 0, shift_finish = 0, remove_2_finish = 0;
    logic        gen_random, isdie, moveT, u, l, r, d, move_down, auto_down;
    logic        remove_1, shift, remove_2, stop, err;
    logic [15:0] piece_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tetris_ctrl #(.DROP_TICKS(8), .DIE_LAT(2), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .clr(clr), .U(U), .D(D), .L(L), .R(R), .pause(pause),
        .move_comp(move_comp), .down_comp(down_comp), .die(die),
        .shift_finish(shift_finish), .remove_2_finish(remove_2_finish),
        .gen_random(gen_random), .isdie(isdie), .moveT(moveT),
        .u(u), .l(l), .r(r), .d(d), .move_down(move_down), .auto_down(auto_down),
        .remove_1(remove_1), .shift(shift), .remove_2(remove_2), .stop(stop),
        .err(err), .piece_cnt(piece_cnt)
    );

    function automatic logic sel(input int which);
        case (which)
            0: sel = move_down;
            1: sel = moveT;
            2: sel = gen_random;
            default: sel = stop;
        endcase
    endfunction

    task automatic wait_req(input int which, input int limit, output int cycles, output bit ok);
        ok = 0;
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            cycles = i;
            if (sel(which)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse_comp(input int which);
        if (which == 0) move_comp = 1; else down_comp = 1;
        @(negedge clk);
        move_comp = 0;
        down_comp = 0;
    endtask

    task automatic test_reset;
        logic [13:0] outs;
        clr = 1;
        repeat (3) @(negedge clk);
        outs = {gen_random, isdie, moveT, u, l, r, d, move_down, auto_down, remove_1, shift, remove_2, stop, err};
        checks++;
        if (outs !== 14'd0 || piece_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b cnt %0d want 0 cnt 0", outs, piece_cnt);
        end
        clr = 0;
        @(negedge clk);
        checks++;
        if (gen_random !== 1'b1 || isdie !== 1'b0 || piece_cnt !== 16'd1) begin
            errors++;
            $display("FAIL spawn_cycle1 got gen %b isdie %b cnt %0d want 1 0 1", gen_random, isdie, piece_cnt);
        end
        @(negedge clk);
        checks++;
        if (gen_random !== 1'b0 || isdie !== 1'b1) begin
            errors++;
            $display("FAIL check_cycle2 got gen %b isdie %b want 0 1", gen_random, isdie);
        end
    endtask

    task automatic test_gravity;
        int  cyc;
        bit  ok;
        wait_req(0, 20, cyc, ok);
        checks++;
        if (!ok || cyc != 7 || auto_down !== 1'b1) begin
            errors++;
            $display("FAIL first_gravity got ok %0d cycles %0d auto %b want 1 7 1", ok, cyc, auto_down);
        end
        pulse_comp(0);
        wait_req(0, 20, cyc, ok);
        checks++;
        if (!ok || cyc != 7 || auto_down !== 1'b1) begin
            errors++;
            $display("FAIL gravity_period got ok %0d cycles %0d auto %b want 1 7 1", ok, cyc, auto_down);
        end
        pulse_comp(0);
    endtask

    task automatic test_move;
        int cyc;
        int high;
        bit ok;
        L = 1;
        @(negedge clk);
        L = 0;
        wait_req(1, 5, cyc, ok);
        checks++;
        if (!ok || {u, l, r, d} !== 4'b0100 || move_down !== 1'b0) begin
            errors++;
            $display("FAIL move_left_dir got ok %0d uldr %b want 1 0100", ok, {u, l, r, d});
        end
        high = 0;
        for (int i = 0; i < 5; i++) begin
            if (moveT) high++;
            move_comp = (i == 2);
            @(negedge clk);
        end
        move_comp = 0;
        checks++;
        if (high != 3 || moveT !== 1'b0 || l !== 1'b0) begin
            errors++;
            $display("FAIL move_hold got %0d cycles moveT %b l %b want 3 0 0", high, moveT, l);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int dropped;
        bit ok;
        wait_req(0, 20, cyc, ok);
        pulse_comp(0);
        wait_req(0, 20, cyc, ok);
        dropped = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!move_down) dropped++;
        end
        checks++;
        if (!ok || dropped != 0) begin
            errors++;
            $display("FAIL drop_held got ok %0d drops %0d want 1 0", ok, dropped);
        end
        D = 1;
        R = 1;
        @(negedge clk);
        D = 0;
        R = 0;
        move_comp = 1;
        @(negedge clk);
        move_comp = 0;
        wait_req(0, 4, cyc, ok);
        checks++;
        if (!ok || auto_down !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gravity_first got ok %0d auto %b want 1 1", ok, auto_down);
        end
        pulse_comp(0);
        wait_req(0, 4, cyc, ok);
        checks++;
        if (!ok || auto_down !== 1'b0) begin
            errors++;
            $display("FAIL b2b_key_d got ok %0d auto %b want 1 0", ok, auto_down);
        end
        pulse_comp(0);
        wait_req(1, 4, cyc, ok);
        checks++;
        if (!ok || {u, l, r, d} !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_key_r got ok %0d uldr %b want 1 0010", ok, {u, l, r, d});
        end
        pulse_comp(0);
    endtask

    task automatic test_pause;
        int bad;
        pause = 1;
        @(negedge clk);
        pause = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (stop) break;
            move_comp = move_down | moveT;
        end
        move_comp = 0;
        checks++;
        if (stop !== 1'b1) begin
            errors++;
            $display("FAIL pause_enter got stop %b want 1", stop);
        end
        L = 1;
        @(negedge clk);
        L = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (move_down || moveT || !stop) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_frozen got %0d active cycles want 0", bad);
        end
        pause = 1;
        @(negedge clk);
        pause = 0;
        checks++;
        if (stop !== 1'b0) begin
            errors++;
            $display("FAIL pause_exit got stop %b want 0", stop);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            move_comp = move_down;
            if (moveT) bad++;
        end
        @(negedge clk);
        move_comp = 0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pause_key_discard got %0d moveT cycles want 0", bad);
        end
    endtask

    task automatic test_lock_clear;
        int cyc;
        bit ok;
        wait_req(0, 20, cyc, ok);
        pulse_comp(1);
        checks++;
        if (!ok || remove_1 !== 1'b1 || move_down !== 1'b0 || shift !== 1'b0) begin
            errors++;
            $display("FAIL lock_mark got ok %0d rm1 %b md %b shift %b want 1 1 0 0", ok, remove_1, move_down, shift);
        end
        @(negedge clk);
        checks++;
        if (remove_1 !== 1'b0 || shift !== 1'b1) begin
            errors++;
            $display("FAIL lock_shift got rm1 %b shift %b want 0 1", remove_1, shift);
        end
        repeat (2) @(negedge clk);
        shift_finish = 1;
        @(negedge clk);
        shift_finish = 0;
        checks++;
        if (shift !== 1'b0 || remove_2 !== 1'b1) begin
            errors++;
            $display("FAIL lock_commit got shift %b rm2 %b want 0 1", shift, remove_2);
        end
        remove_2_finish = 1;
        @(negedge clk);
        remove_2_finish = 0;
        @(negedge clk);
        checks++;
        if (remove_2 !== 1'b0 || gen_random !== 1'b1 || piece_cnt !== 16'd2 || err !== 1'b0) begin
            errors++;
            $display("FAIL lock_respawn got rm2 %b gen %b cnt %0d err %b want 0 1 2 0", remove_2, gen_random, piece_cnt, err);
        end
    endtask

    task automatic test_timeout;
        int cyc;
        int high;
        bit ok;
        wait_req(0, 20, cyc, ok);
        pulse_comp(1);
        @(negedge clk);
        high = 0;
        for (int i = 0; i < 40; i++) begin
            if (!shift) break;
            high++;
            @(negedge clk);
        end
        checks++;
        if (!ok || high != 16 || err !== 1'b1) begin
            errors++;
            $display("FAIL shift_timeout got ok %0d high %0d err %b want 1 16 1", ok, high, err);
        end
        wait_req(2, 3, cyc, ok);
        checks++;
        if (!ok || cyc != 1 || piece_cnt !== 16'd3) begin
            errors++;
            $display("FAIL timeout_respawn got ok %0d cycles %0d cnt %0d want 1 1 3", ok, cyc, piece_cnt);
        end
    endtask

    task automatic test_over;
        int cyc;
        int bad;
        bit ok;
        wait_req(0, 20, cyc, ok);
        #1 clr = 1;
        #1;
        checks++;
        if (!ok || move_down !== 1'b0 || err !== 1'b0 || piece_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_clear got ok %0d md %b err %b cnt %0d want 1 0 0 0", ok, move_down, err, piece_cnt);
        end
        die = 1;
        @(negedge clk);
        clr = 0;
        wait_req(3, 10, cyc, ok);
        checks++;
        if (!ok || cyc != 5 || piece_cnt !== 16'd1) begin
            errors++;
            $display("FAIL over_enter got ok %0d cycles %0d cnt %0d want 1 5 1", ok, cyc, piece_cnt);
        end
        L = 1;
        D = 1;
        pause = 1;
        @(negedge clk);
        L = 0;
        D = 0;
        pause = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (moveT || move_down || gen_random || isdie || !stop) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL over_idle got %0d active cycles want 0", bad);
        end
        clr = 1;
        die = 0;
        @(negedge clk);
        checks++;
        if (stop !== 1'b0 || piece_cnt !== 16'd0) begin
            errors++;
            $display("FAIL over_clear got stop %b cnt %0d want 0 0", stop, piece_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_gravity;
        test_move;
        test_back_to_back;
        test_pause;
        test_lock_clear;
        test_timeout;
        test_over;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
